// File: rtl/sp_ram_pkg.sv
// Shared definitions for the byte-enable single-port RAM.
package sp_ram_pkg;

    // Zero-init sequencer state
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_e;

    // Read-during-write behaviour
    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;

    // Number of byte-enable lanes in one word
    function automatic int unsigned num_bytes(input int unsigned data_width,
                                              input int unsigned byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/sp_ram_be_if.sv
// Access port of the byte-enable single-port RAM.
interface sp_ram_be_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    import sp_ram_pkg::*;

    localparam int unsigned NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);

    logic                  ce;
    logic                  we;
    logic [NUM_BYTES-1:0]  be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  init_busy;

    modport master (
        output ce, we, be, addr, data,
        input  q, q_valid, init_busy
    );

    modport slave (
        input  ce, we, be, addr, data,
        output q, q_valid, init_busy
    );

endinterface

// File: rtl/sp_ram_init_fsm.sv
// Zero-init sequencer: after reset walks every word once, then stays READY.
module sp_ram_init_fsm
    import sp_ram_pkg::*;
#(
    parameter int unsigned RAM_DEPTH  = 256,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned INIT_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] init_addr,
    output logic                  init_we
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam init_state_e RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_READY;

    init_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // Next state: count through the array, leave INIT after the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_READY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State and counter registers; reset restarts the walk from word 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q == ST_INIT);
    assign init_addr = cnt_q;
    assign init_we   = busy;

endmodule

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM with byte enables, selectable read-during-write,
// optional output register and hardware zero-init after reset.
module sp_ram_be
    import sp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 256,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned INIT_ZERO  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    sp_ram_be_if.slave  bus
);

    localparam int unsigned NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);

    logic                  init_busy;
    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  accept;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_BYTES-1:0]  lane_we;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_word_q, rd_word_d;

    sp_ram_init_fsm #(
        .RAM_DEPTH  (RAM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_ZERO  (INIT_ZERO)
    ) u_init_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy      (init_busy),
        .init_addr (init_addr),
        .init_we   (init_we)
    );

    assign bus.init_busy = init_busy;

    // User port is shut out while the sequencer owns the array
    assign accept   = rst_n && bus.ce && !init_busy;
    assign in_range = 32'(bus.addr) < RAM_DEPTH;
    assign wr_addr  = init_busy ? init_addr : bus.addr;
    assign wr_data  = init_busy ? '0 : bus.data;

    // Per-lane write enables and the merged word seen by write-first reads
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
        assign lane_we[i] = rst_n && (init_we || (accept && bus.we && bus.be[i] && in_range));
        assign merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
            (bus.we && bus.be[i]) ? bus.data[i*BYTE_WIDTH +: BYTE_WIDTH]
                                  : old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    // Pre-write word at the user address; out-of-range addresses read as zero
    always_comb begin
        old_word = '0;
        if (in_range) begin
            old_word = mem[bus.addr];
        end
    end

    assign rd_word = !in_range ? '0
                   : ((RDW_MODE == RDW_WRITE_FIRST) ? merged_word : old_word);

    // Array write: only enabled lanes update, the rest keep their bytes
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (lane_we[i]) begin
                mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Read stage: word is held at zero whenever no access was accepted
    always_comb begin
        rd_valid_d = accept;
        rd_word_d  = accept ? rd_word : '0;
    end

    // Read register; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_word_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_word_q  <= rd_word_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  out_valid_q, out_valid_d;
        logic [DATA_WIDTH-1:0] out_word_q, out_word_d;

        // Extra output stage carries {valid, word} unchanged
        always_comb begin
            out_valid_d = rd_valid_q;
            out_word_d  = rd_word_q;
        end

        // Output register; cleared with the read stage on reset
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
                out_word_q  <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                out_word_q  <= out_word_d;
            end
        end

        assign bus.q_valid = out_valid_q;
        assign bus.q       = out_word_q;
    end else begin : g_no_out_reg
        assign bus.q_valid = rd_valid_q;
        assign bus.q       = rd_word_q;
    end

endmodule
